// File: rtl/z80_pkg.sv
`default_nettype none
// ============================================================================
// Module  : z80_pkg
// Purpose : Shared flag bit positions, block-op descriptor and sequencer
//           state encodings for the Z80 block transfer/compare sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package z80_pkg;

  localparam int FLAG_C_BIT  = 0;
  localparam int FLAG_N_BIT  = 1;
  localparam int FLAG_PV_BIT = 2;
  localparam int FLAG_F3_BIT = 3;
  localparam int FLAG_H_BIT  = 4;
  localparam int FLAG_F5_BIT = 5;
  localparam int FLAG_Z_BIT  = 6;
  localparam int FLAG_S_BIT  = 7;

  typedef struct packed {
    logic cp;
    logic dec;
    logic rep;
  } block_op_t;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE = 3'd0;
  localparam seq_state_t ST_RD   = 3'd1;
  localparam seq_state_t ST_WR   = 3'd2;
  localparam seq_state_t ST_UPD  = 3'd3;
  localparam seq_state_t ST_GAP  = 3'd4;
  localparam seq_state_t ST_DONE = 3'd5;

endpackage : z80_pkg
`default_nettype wire

// File: rtl/z80_block_flags.sv
`default_nettype none
// ============================================================================
// Module  : z80_block_flags
// Purpose : Combinational F for one block-op iteration. Optional macro
//           Z80_BLOCK_UNDOC_FLAGS_EN makes F5/F3 follow silicon behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module z80_block_flags
  import z80_pkg::*;
(
  input  logic        cp,
  input  logic [7:0]  a,
  input  logic [7:0]  mem_byte,
  input  logic [7:0]  f_in,
  input  logic [15:0] bc_new,
  output logic [7:0]  f_out
);

  logic [7:0] diff;
  logic       half_borrow;

  assign diff        = a - mem_byte;
  assign half_borrow = (a[3:0] < mem_byte[3:0]);

`ifdef Z80_BLOCK_UNDOC_FLAGS_EN
  logic [7:0] undoc_n;
  assign undoc_n = cp ? (diff - {7'd0, half_borrow}) : (a + mem_byte);
`endif

  always_comb begin
    f_out = f_in;
    if (cp) begin
      f_out[FLAG_S_BIT] = diff[7];
      f_out[FLAG_Z_BIT] = (diff == 8'h00);
      f_out[FLAG_H_BIT] = half_borrow;
      f_out[FLAG_N_BIT] = 1'b1;
    end else begin
      f_out[FLAG_H_BIT] = 1'b0;
      f_out[FLAG_N_BIT] = 1'b0;
    end
    f_out[FLAG_PV_BIT] = (bc_new != 16'h0000);
`ifdef Z80_BLOCK_UNDOC_FLAGS_EN
    f_out[FLAG_F5_BIT] = undoc_n[1];
    f_out[FLAG_F3_BIT] = undoc_n[3];
`endif
  end

endmodule : z80_block_flags
`default_nettype wire

// File: rtl/z80_block_op_seq.sv
`default_nettype none
// ============================================================================
// Module  : z80_block_op_seq
// Purpose : Multi-cycle sequencer for LDI/LDD/LDIR/LDDR/CPI/CPD/CPIR/CPDR.
//           F5/F3 behaviour selectable via Z80_BLOCK_UNDOC_FLAGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module z80_block_op_seq
  import z80_pkg::*;
#(
  parameter int REP_GAP  = 5,
  parameter int INT_EXIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op_cp,
  input  logic        op_dec,
  input  logic        op_rep,
  input  logic [7:0]  reg_a,
  input  logic [7:0]  f_in,
  input  logic [15:0] bc_in,
  input  logic [15:0] de_in,
  input  logic [15:0] hl_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        int_pending,
  output logic        busy,
  output logic        done,
  output logic        ip_rewind,
  output logic [7:0]  f_out,
  output logic [15:0] bc_out,
  output logic [15:0] de_out,
  output logic [15:0] hl_out
);

  localparam int GAP_W = (REP_GAP > 1) ? $clog2(REP_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((REP_GAP > 0) ? (REP_GAP - 1) : 0);

  seq_state_t       state;
  block_op_t        op;
  logic [7:0]       a_reg;
  logic [7:0]       f_reg;
  logic [15:0]      bc_reg;
  logic [15:0]      de_reg;
  logic [15:0]      hl_reg;
  logic [7:0]       data_byte;
  logic [GAP_W-1:0] gap_cnt;
  logic             rewind;

  logic [15:0] bc_new;
  logic [15:0] step;
  logic [7:0]  f_new;
  logic        cont;

  assign bc_new = bc_reg - 16'd1;
  assign step   = op.dec ? 16'hFFFF : 16'h0001;

  z80_block_flags u_flags (
    .cp       (op.cp),
    .a        (a_reg),
    .mem_byte (data_byte),
    .f_in     (f_reg),
    .bc_new   (bc_new),
    .f_out    (f_new)
  );

  // A compare stops on a match even when BC has not run out.
  assign cont = op.rep && (bc_new != 16'h0000) && !(op.cp && f_new[FLAG_Z_BIT]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op        <= '0;
      a_reg     <= 8'h00;
      f_reg     <= 8'h00;
      bc_reg    <= 16'h0000;
      de_reg    <= 16'h0000;
      hl_reg    <= 16'h0000;
      data_byte <= 8'h00;
      gap_cnt   <= '0;
      rewind    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op     <= '{cp: op_cp, dec: op_dec, rep: op_rep};
            a_reg  <= reg_a;
            f_reg  <= f_in;
            bc_reg <= bc_in;
            de_reg <= de_in;
            hl_reg <= hl_in;
            rewind <= 1'b0;
            state  <= ST_RD;
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            data_byte <= mem_rdata;
            state     <= op.cp ? ST_UPD : ST_WR;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            state <= ST_UPD;
          end
        end
        ST_UPD: begin
          bc_reg <= bc_new;
          hl_reg <= hl_reg + step;
          if (!op.cp) begin
            de_reg <= de_reg + step;
          end
          f_reg <= f_new;
          if (!cont) begin
            state <= ST_DONE;
          end else if ((INT_EXIT != 0) && int_pending) begin
            rewind <= 1'b1;
            state  <= ST_DONE;
          end else if (REP_GAP == 0) begin
            state <= ST_RD;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_RD;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = (state == ST_RD) || (state == ST_WR);
  assign mem_we    = (state == ST_WR);
  assign mem_addr  = (state == ST_WR) ? de_reg : ((state == ST_RD) ? hl_reg : 16'h0000);
  assign mem_wdata = (state == ST_WR) ? data_byte : 8'h00;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign ip_rewind = rewind && (state == ST_DONE);
  assign f_out     = f_reg;
  assign bc_out    = bc_reg;
  assign de_out    = de_reg;
  assign hl_out    = hl_reg;

endmodule : z80_block_op_seq
`default_nettype wire
